// File: rtl/mu_seq_pkg.sv
// mu_seq_pkg: definitions shared by the mu buffer sequencer and the mu circular buffer.
//   MU_BUF_SIZE : depth of the mu circular buffer. The sequencer's column mirror
//                 must use the same value, or its pointer copy drifts.
//   mu_state_e  : sequencer FSM states.
package mu_seq_pkg;

    localparam int MU_BUF_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ALIGN  = 2'd2,
        DONE   = 2'd3
    } mu_state_e;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-N up counter.
//   clk   in  : clock
//   rst   in  : synchronous active-high reset (count -> 0)
//   inc   in  : advance the count by one this cycle
//   clr   in  : synchronous clear (count -> 0)
//   count out : current count, 0..N-1
//   wrap  out : inc is asserted while count==N-1, so the count returns to 0 on this edge
module wrap_counter #(
    parameter  int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = inc && (count == W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc)
            count <= wrap ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/mu_buffer_sequencer.sv
// mu_buffer_sequencer: sequences the mu circular buffer that feeds one PE column group.
// The buffer read pointer is not visible from outside the buffer. col_idx mirrors it by
// counting every read_en this block issues. An aborted job walks the pointer back round
// to column 0 so that the next job always starts aligned.
//   clk, rst     : clock, synchronous active-high reset. rst must also reset the buffer.
//   start        : job request. Taken only in IDLE and only when abort=0.
//   num_passes   : passes in the job. Sampled when start is taken.
//   pe_ready     : the PE array can take a beat this cycle.
//   abort        : cancels the job that is streaming.
//   buf_read_en  : read_en to the circular buffer. Advances the buffer pointer.
//   data_valid   : the buffer output is a beat for the PE array.
//   col_idx      : mirror of the buffer read pointer.
//   pass_idx     : current pass, counted from 0.
//   first_col    : the beat is column 0.
//   last_col     : the beat is column SIZE-1.
//   busy         : the FSM is not idle.
//   done         : one-cycle pulse when a job finishes or when abort alignment completes.
module mu_buffer_sequencer
    import mu_seq_pkg::*;
#(
    parameter  int SIZE   = MU_BUF_SIZE,
    parameter  int PASS_W = 8,
    localparam int COL_W  = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PASS_W-1:0] num_passes,
    input  logic              pe_ready,
    input  logic              abort,
    output logic              buf_read_en,
    output logic              data_valid,
    output logic [COL_W-1:0]  col_idx,
    output logic [PASS_W-1:0] pass_idx,
    output logic              first_col,
    output logic              last_col,
    output logic              busy,
    output logic              done
);

    mu_state_e         state;
    logic [PASS_W-1:0] num_q;
    logic              beat;
    logic              col_inc;
    logic              col_wrap;

    // abort takes priority over a beat. The buffer output only counts as valid when it is
    // actually consumed, so that valid and read_en stay identical while streaming.
    assign beat        = (state == STREAM) && pe_ready && !abort;
    assign col_inc     = beat || (state == ALIGN);

    assign data_valid  = beat;
    assign buf_read_en = col_inc;
    assign first_col   = beat && (col_idx == '0);
    assign last_col    = beat && (col_idx == COL_W'(SIZE - 1));
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    // In IDLE the mirror is held at 0. This matches the buffer pointer after a reset,
    // after a completed job, and after an abort alignment.
    wrap_counter #(.N(SIZE)) u_col (
        .clk   (clk),
        .rst   (rst),
        .inc   (col_inc),
        .clr   (state == IDLE),
        .count (col_idx),
        .wrap  (col_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            num_q    <= '0;
            pass_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        num_q    <= num_passes;
                        pass_idx <= '0;
                        state    <= (num_passes == '0) ? DONE : STREAM;
                    end
                end
                STREAM: begin
                    if (abort) begin
                        // At column 0 the pointer is already aligned, so no walk is needed.
                        state <= (col_idx == '0) ? DONE : ALIGN;
                    end else if (col_wrap) begin
                        pass_idx <= pass_idx + 1'b1;
                        if (pass_idx == num_q - 1'b1)
                            state <= DONE;
                    end
                end
                ALIGN: begin
                    if (col_wrap)
                        state <= DONE;
                end
                DONE: begin
                    pass_idx <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mu_buffer_sequencer.sv
module tb_mu_buffer_sequencer;
    localparam int SIZE   = 8;
    localparam int PASS_W = 8;
    localparam int COL_W  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [PASS_W-1:0] num_passes = '0;
    logic              pe_ready = 1'b0;
    logic              abort = 1'b0;
    logic              buf_read_en, data_valid, first_col, last_col, busy, done;
    logic [COL_W-1:0]  col_idx;
    logic [PASS_W-1:0] pass_idx;

    mu_buffer_sequencer #(.SIZE(SIZE), .PASS_W(PASS_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_passes(num_passes),
        .pe_ready(pe_ready), .abort(abort), .buf_read_en(buf_read_en),
        .data_valid(data_valid), .col_idx(col_idx), .pass_idx(pass_idx),
        .first_col(first_col), .last_col(last_col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model. A job is a run of np*SIZE beats, and beat_no counts the beats
    // consumed so far. The buffer itself is modelled as a pointer into a ring whose slot k
    // holds the value k. The data seen at a beat is therefore the model pointer, and the
    // DUT col_idx must equal it.
    int m_phase = 0;   // 0 idle, 1 streaming, 2 walking back to column 0, 3 done pulse
    int m_beat  = 0;
    int m_np    = 0;
    int m_ptr   = 0;
    bit m_live  = 0;

    // Totals observed at the DUT ports. Only the monitor writes these.
    int c_rd = 0, c_vld = 0, c_first = 0, c_last = 0, c_done = 0, c_align = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_beat = 0; m_ptr = 0; m_live = 1;
        end else begin
            case (m_phase)
                0: if (start && !abort) begin
                       m_np = int'(num_passes); m_beat = 0;
                       m_phase = (m_np == 0) ? 3 : 1;
                   end
                1: if (abort) m_phase = (m_ptr == 0) ? 3 : 2;
                   else if (pe_ready) begin
                       m_beat++; m_ptr = (m_ptr + 1) % SIZE;
                       if (m_beat == m_np * SIZE) m_phase = 3;
                   end
                2: begin
                       m_ptr++;
                       if (m_ptr == SIZE) begin m_ptr = 0; m_phase = 3; end
                   end
                default: begin m_phase = 0; m_beat = 0; end
            endcase
        end
    end

    // Compare process. It runs on every falling edge, when inputs are stable.
    always @(negedge clk) begin
        if (m_live && !rst) begin
            bit e_vld, e_rd;
            logic [15:0] exp_v, act_v;
            e_vld = (m_phase == 1) && pe_ready && !abort;
            e_rd  = e_vld || (m_phase == 2);
            exp_v = {e_rd, e_vld, e_vld && m_ptr == 0, e_vld && m_ptr == SIZE-1,
                     m_phase != 0, m_phase == 3, 3'(m_ptr), 8'(m_beat / SIZE)};
            act_v = {buf_read_en, data_valid, first_col, last_col, busy, done, col_idx, pass_idx};
            check("model_cycle", int'(act_v), int'(exp_v));
            if (data_valid) check("beat_data", int'(col_idx), m_ptr);
        end
        if (buf_read_en) c_rd++;
        if (data_valid) c_vld++;
        if (first_col) c_first++;
        if (last_col) c_last++;
        if (done) c_done++;
        if (buf_read_en && !data_valid) c_align++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic int outs_all();
        return int'({buf_read_en, data_valid, first_col, last_col, busy, done, col_idx, pass_idx});
    endfunction

    // Steps until done is seen, bounded. Returns the number of steps taken, or -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin n = i; return; end
            step();
        end
        check("wait_done_timeout", 0, 1);
    endtask

    task automatic wait_col(input int pass, input int col);
        for (int i = 0; i < 100; i++) begin
            if (int'(pass_idx) == pass && int'(col_idx) == col) return;
            step();
        end
        check("wait_col_timeout", 0, 1);
    endtask

    initial begin
        int n, s_rd, s_first, s_last, s_align;
        rst = 1; step(); step(); rst = 0;
        check("reset_outputs", outs_all(), 0);

        // T1: two passes with no stalls. 16 back-to-back beats, then done.
        s_rd = c_rd; s_first = c_first; s_last = c_last;
        start = 1; num_passes = 2; pe_ready = 1; step(); start = 0;
        wait_done(n);
        check("t1_cycles_to_done", n, 16);
        check("t1_beats", c_rd - s_rd, 16);
        check("t1_first_cols", c_first - s_first, 2);
        check("t1_last_cols", c_last - s_last, 2);
        check("t1_col_at_done", int'(col_idx), 0);
        step();
        check("t1_idle_after", int'(busy), 0);

        // T2: one pass, with pe_ready low on beats 3 and 5.
        s_rd = c_rd;
        start = 1; num_passes = 1; step(); start = 0;
        n = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            pe_ready = !((c == 3) || (c == 5));
            step(); n++;
        end
        pe_ready = 1;
        check("t2_cycles", n, 10);
        check("t2_beats", c_rd - s_rd, 8);
        step();

        // T4: zero passes. done comes in the cycle after the start cycle, with no reads.
        s_rd = c_rd;
        start = 1; num_passes = 0; step(); start = 0;
        check("t4_done_next", int'(done), 1);
        step(); step();
        check("t4_no_reads", c_rd - s_rd, 0);

        // T3: abort at pass 1, column 5. The walk issues 3 reads with valid low.
        start = 1; num_passes = 3; step(); start = 0;
        wait_col(1, 5);
        s_align = c_align;
        abort = 1; step(); abort = 0; pe_ready = 0;
        wait_done(n);
        check("t3_align_cycles", n, 3);
        check("t3_align_reads", c_align - s_align, 3);
        step(); pe_ready = 1;
        start = 1; num_passes = 1; step(); start = 0;
        check("t3_next_col0", int'(col_idx), 0);
        check("t3_next_first", int'(first_col), 1);
        wait_done(n); step();

        // T5: start is ignored during STREAM and DONE. start with abort in IDLE stays IDLE.
        s_rd = c_rd;
        start = 1; num_passes = 1; step(); num_passes = 3;
        wait_done(n);
        step(); start = 0;
        check("t5_only_one_pass", c_rd - s_rd, 8);
        check("t5_idle", int'(busy), 0);
        start = 1; abort = 1; step(); start = 0; abort = 0;
        check("t5_start_abort_idle", int'(busy), 0);

        // T6: reset in the middle of a job.
        start = 1; num_passes = 2; step(); start = 0;
        wait_col(0, 4);
        rst = 1; step(); rst = 0;
        check("t6_reset_outputs", outs_all(), 0);
        start = 1; num_passes = 1; step(); start = 0;
        check("t6_restart_col0", int'(col_idx), 0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom % 250) == 0;
            start      = ($urandom % 6) == 0;
            abort      = ($urandom % 20) == 0;
            pe_ready   = ($urandom % 4) != 0;
            num_passes = PASS_W'($urandom % 4);
            step();
        end
        rst = 0; start = 0; abort = 0;
        step();
        check("random_done_seen", int'(c_done > 5), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
